alu_nibble_sequencer: RTL and testbench
=======================================

# alu_nibble_sequencer

Multi-cycle initiator that drives the 4-bit ALU to execute one word-wide operation (4·NIBBLES bits) as a serial chain of nibble operations, least-significant nibble first, propagating carry between nibbles. It sits between a request/response client and the existing combinational ALU, which the parent instantiates and connects to the `alu_*` ports. It owns operand slicing, carry chaining, result assembly and the valid/ready handshakes.

## Interface
- `NIBBLES`, default 4: number of nibbles per word. Word width W = 4·NIBBLES. Legal range 2..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  sequencer can accept; high only in IDLE.
- `req_op`  in  3  opcode: ADD=0, SUB=1, AND=4, OR=5, XOR=6; other codes are illegal.
- `req_a`, `req_b`  in  W  operands.
- `req_cin`  in  1  carry into nibble 0 (ADD/SUB only).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  client accepts result.
- `rsp_y`  out  W  assembled result.
- `rsp_cout`  out  1  carry out of the top nibble.
- `rsp_ovf`  out  1  overflow from the top nibble.
- `alu_a`, `alu_b`  out  4  current operand nibbles to the ALU.
- `alu_op`  out  3  opcode to the ALU.
- `alu_cin`  out  1  carry into the ALU.
- `alu_y`  in  4  ALU result.
- `alu_cout`, `alu_ovf`  in  1  ALU carry and overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch op, a, b and cin; set idx=0; go to RUN.
- RUN: drive `alu_a`=a[4·idx+3:4·idx], `alu_b`=b[same slice], `alu_op`=latched op.
  - `alu_cin`: the latched cin when idx=0, otherwise the stored carry.
  - For AND/OR/XOR and illegal opcodes, `alu_cin` is forced to 0.
- Each RUN edge:
  - Store `alu_y` into y slice idx.
  - Update the carry register with `alu_cout`.
  - Increment idx.
  - At idx=NIBBLES-1, also store `alu_ovf`, then go to DONE.
- Flag rules: `rsp_cout` and `rsp_ovf` come from the top nibble for ADD/SUB only. For all other opcodes they are forced to 0.
- Illegal opcodes run the full sequence; the result is whatever the ALU returns (0 for the current ALU).
- DONE: `rsp_valid`=1 and the outputs are held stable. On `rsp_ready`, go to IDLE.
- Outside RUN, `alu_a`, `alu_b`, `alu_op` and `alu_cin` are driven to 0.
- SUB borrow convention is inherited from the ALU. The sequencer only chains `alu_cout` into the next `alu_cin`.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_y`=0, `rsp_cout`=0, `rsp_ovf`=0, all `alu_*` outputs 0.
- Accept on edge T0. The RUN cycles are T0..T0+NIBBLES-1. `rsp_valid` rises after edge T0+NIBBLES, so latency is NIBBLES+1 cycles from request to response for NIBBLES=4 (5 cycles).
- No back-to-back acceptance: `req_ready` rises the cycle after the response handshake. Throughput is one operation per NIBBLES+2 cycles at best.
- `req_*` inputs are ignored outside IDLE. Operands may change after the accept edge.
- `rsp_y`, `rsp_cout` and `rsp_ovf` hold their values from DONE until the next completion. They are valid only while `rsp_valid`=1.
- The ALU path is combinational within one cycle: `alu_*` outputs to `alu_y` to the capture register.
- `rst` mid-RUN or in DONE: the operation is abandoned, all outputs return to reset values on the next edge, and no response is produced.

## Configuration
- `ALU_SEQ_ZERO_FLAG_EN` defined:
  - Adds output `rsp_zero` (1 bit), registered with `rsp_y`.
  - `rsp_zero`=1 when all W result bits are 0; reset value 0.
  - It is the AND of per-nibble zero bits accumulated during RUN. No W-wide reduction at the end.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `alu_seq_pkg`:
  - Opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR.
  - State enum (IDLE/RUN/DONE).
  - Helper function `is_arith(op)`.
- No sub-module; the ALU stays external so this block can be verified against a model.
- idx counter width is $clog2(NIBBLES).

## Test plan
All scenarios use NIBBLES=4 and the real ALU connected.
- ADD 0x00FF+0x0001, cin=0 -> `rsp_y`=0x0100, `rsp_cout`=0, `rsp_ovf`=0. `rsp_valid` is first high 5 cycles after the request.
- ADD 0xFFFF+0x0001 -> 0x0000, `rsp_cout`=1. ADD 0x7FFF+0x0001 -> 0x8000, `rsp_ovf`=1.
- XOR 0xA5A5^0xFFFF -> 0x5A5A, flags 0. Check that `alu_cin` stays 0 during all RUN cycles.
- Illegal op 3 with a=0x1234, b=0x5678 -> `rsp_y`=0x0000, `rsp_cout`=0, `rsp_ovf`=0.
- Hold `rsp_ready` low 3 cycles in DONE -> `rsp_y` stable, `req_ready`=0, a new `req_valid` is ignored. After `rsp_ready`, `req_ready`=1 next cycle.
- Assert `rst` at idx=2 of an ADD -> next cycle `req_ready`=1, `rsp_valid`=0, `rsp_y`=0, `alu_*`=0.
  - A subsequent ADD 0x0003+0x0004 -> 0x0007.
  - With `ALU_SEQ_ZERO_FLAG_EN` defined, also check `rsp_zero`=1 for AND 0xF0F0&0x0F0F.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, sequencer state encoding and helpers for alu_nibble_sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only ADD/SUB chain a carry between nibbles and report carry/overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Drives an external 4-bit ALU through NIBBLES serial steps to perform one word-wide op.
// Optional `ALU_SEQ_ZERO_FLAG_EN adds rsp_zero, accumulated per nibble during RUN.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [4*NIBBLES-1:0]   req_a,
  input  logic [4*NIBBLES-1:0]   req_b,
  input  logic                   req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_y,
  output logic                   rsp_cout,
  output logic                   rsp_ovf,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_op,
  output logic                   alu_cin,
  input  logic [3:0]             alu_y,
  input  logic                   alu_cout,
  input  logic                   alu_ovf
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic                   rsp_zero
`endif
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic [2:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cin;
  logic            r_carry;
  logic [W-1:0]    r_yWork;
  logic [W-1:0]    r_rspY;
  logic            r_rspCout;
  logic            r_rspOvf;

  logic [IDXW+1:0] w_shamt;
  logic [W-1:0]    w_mask;
  logic [W-1:0]    w_yNext;
  logic            w_last;

  assign w_shamt = {r_idx, 2'b00};
  assign w_mask  = {{(W-4){1'b0}}, 4'hF} << w_shamt;
  assign w_yNext = (r_yWork & ~w_mask) | ({{(W-4){1'b0}}, alu_y} << w_shamt);
  assign w_last  = (r_idx == IDX_LAST);

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_y     = r_rspY;
  assign rsp_cout  = r_rspCout;
  assign rsp_ovf   = r_rspOvf;

  // ALU inputs are only live in RUN; logic ops never see a carry in.
  always_comb begin
    alu_a   = 4'h0;
    alu_b   = 4'h0;
    alu_op  = 3'd0;
    alu_cin = 1'b0;
    if (r_state == ST_RUN) begin
      alu_a  = 4'(r_a >> w_shamt);
      alu_b  = 4'(r_b >> w_shamt);
      alu_op = r_op;
      if (is_arith(r_op)) begin
        alu_cin = (r_idx == '0) ? r_cin : r_carry;
      end
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic r_zeroAcc;
  logic r_rspZero;
  logic w_zeroNext;

  assign w_zeroNext = ((r_idx == '0) ? 1'b1 : r_zeroAcc) & (alu_y == 4'h0);
  assign rsp_zero   = r_rspZero;

  // Zero flag is built nibble by nibble so no word-wide reduction is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zeroAcc <= 1'b0;
      r_rspZero <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_zeroAcc <= w_zeroNext;
      if (w_last) begin
        r_rspZero <= w_zeroNext;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_op      <= 3'd0;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_carry   <= 1'b0;
      r_yWork   <= '0;
      r_rspY    <= '0;
      r_rspCout <= 1'b0;
      r_rspOvf  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_a     <= req_a;
            r_b     <= req_b;
            r_cin   <= req_cin;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_yWork <= w_yNext;
          r_carry <= alu_cout;
          // Response registers only change at completion so the previous result stays put.
          if (w_last) begin
            r_rspY    <= w_yNext;
            r_rspCout <= is_arith(r_op) & alu_cout;
            r_rspOvf  <= is_arith(r_op) & alu_ovf;
            r_idx     <= '0;
            r_state   <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 4-bit ALU model attached.
// Define ALU_SEQ_ZERO_FLAG_EN to also exercise rsp_zero.
module tb_alu_nibble_sequencer;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  reqOp;
  logic [15:0] reqA;
  logic [15:0] reqB;
  logic        reqCin;
  logic        rspValid;
  logic        rspReady;
  logic [15:0] rspY;
  logic        rspCout;
  logic        rspOvf;
  logic [3:0]  aluA;
  logic [3:0]  aluB;
  logic [2:0]  aluOp;
  logic        aluCin;
  logic [3:0]  aluY;
  logic        aluCout;
  logic        aluOvf;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        rspZero;
`endif

  int testsRun;
  int failCount;
  int latency;

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_op    (reqOp),
    .req_a     (reqA),
    .req_b     (reqB),
    .req_cin   (reqCin),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_y     (rspY),
    .rsp_cout  (rspCout),
    .rsp_ovf   (rspOvf),
    .alu_a     (aluA),
    .alu_b     (aluB),
    .alu_op    (aluOp),
    .alu_cin   (aluCin),
    .alu_y     (aluY),
    .alu_cout  (aluCout),
    .alu_ovf   (aluOvf)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    .rsp_zero  (rspZero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the real combinational ALU: SUB reports a borrow on cout.
  logic [4:0] aluWide;
  always_comb begin
    aluY    = 4'h0;
    aluCout = 1'b0;
    aluOvf  = 1'b0;
    aluWide = 5'd0;
    case (aluOp)
      3'd0: begin
        aluWide = {1'b0, aluA} + {1'b0, aluB} + {4'b0, aluCin};
        aluY    = aluWide[3:0];
        aluCout = aluWide[4];
        aluOvf  = (aluA[3] == aluB[3]) && (aluY[3] != aluA[3]);
      end
      3'd1: begin
        aluWide = {1'b0, aluA} - {1'b0, aluB} - {4'b0, aluCin};
        aluY    = aluWide[3:0];
        aluCout = aluWide[4];
        aluOvf  = (aluA[3] != aluB[3]) && (aluY[3] != aluA[3]);
      end
      3'd4: aluY = aluA & aluB;
      3'd5: aluY = aluA | aluB;
      3'd6: aluY = aluA ^ aluB;
      default: aluY = 4'h0;
    endcase
  end

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request from IDLE and waits (bounded) for rsp_valid; operands are scrambled after accept.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input bit watchCin, output int cycles);
    reqOp    = op;
    reqA     = a;
    reqB     = b;
    reqCin   = cin;
    reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqA     = 16'hDEAD;
    reqB     = 16'hBEEF;
    reqCin   = ~cin;
    cycles   = 1;
    while (!rspValid && cycles < 20) begin
      if (watchCin) checkOutput("xorAluCin", {31'd0, aluCin}, 32'd0);
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!rspValid) checkOutput("rspTimeout", 32'd0, 32'd1);
  endtask

  task automatic completeHandshake(input string tag);
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
    checkOutput(tag, {30'd0, reqReady, rspValid}, 32'h2);
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst       = 1'b1;
    reqValid  = 1'b0;
    reqOp     = 3'd0;
    reqA      = 16'h0;
    reqB      = 16'h0;
    reqCin    = 1'b0;
    rspReady  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rstReqReady", {31'd0, reqReady}, 32'd1);
    checkOutput("rstRspValid", {31'd0, rspValid}, 32'd0);
    checkOutput("rstRspY", {16'd0, rspY}, 32'd0);
    checkOutput("rstFlags", {30'd0, rspCout, rspOvf}, 32'd0);
    checkOutput("rstAluBus", {20'd0, aluA, aluB, aluOp, aluCin}, 32'd0);

    applyStimulus(3'd0, 16'h00FF, 16'h0001, 1'b0, 1'b0, latency);
    checkOutput("addLatency", latency, 32'd5);
    checkOutput("add00FF", {16'd0, rspY}, 32'h0100);
    checkOutput("add00FFFlags", {30'd0, rspCout, rspOvf}, 32'd0);
    completeHandshake("addHandshake");

    applyStimulus(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, latency);
    checkOutput("addFFFF", {16'd0, rspY}, 32'h0000);
    checkOutput("addFFFFFlags", {30'd0, rspCout, rspOvf}, 32'h2);
    completeHandshake("addFFFFHandshake");

    applyStimulus(3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, latency);
    checkOutput("add7FFF", {16'd0, rspY}, 32'h8000);
    checkOutput("add7FFFFlags", {30'd0, rspCout, rspOvf}, 32'h1);
    completeHandshake("add7FFFHandshake");

    applyStimulus(3'd0, 16'h0001, 16'h0001, 1'b1, 1'b0, latency);
    checkOutput("addCin", {16'd0, rspY}, 32'h0003);
    completeHandshake("addCinHandshake");

    applyStimulus(3'd1, 16'h0000, 16'h0001, 1'b0, 1'b0, latency);
    checkOutput("subBorrow", {16'd0, rspY}, 32'hFFFF);
    checkOutput("subBorrowFlags", {30'd0, rspCout, rspOvf}, 32'h2);
    completeHandshake("subHandshake");

    applyStimulus(3'd6, 16'hA5A5, 16'hFFFF, 1'b1, 1'b1, latency);
    checkOutput("xorResult", {16'd0, rspY}, 32'h5A5A);
    checkOutput("xorFlags", {30'd0, rspCout, rspOvf}, 32'd0);
    completeHandshake("xorHandshake");

    applyStimulus(3'd3, 16'h1234, 16'h5678, 1'b1, 1'b0, latency);
    checkOutput("illegalResult", {16'd0, rspY}, 32'h0000);
    checkOutput("illegalFlags", {30'd0, rspCout, rspOvf}, 32'd0);
    completeHandshake("illegalHandshake");

    // Response held while the client stalls; a fresh request must be ignored.
    applyStimulus(3'd5, 16'h1200, 16'h0034, 1'b0, 1'b0, latency);
    reqOp    = 3'd0;
    reqA     = 16'h0001;
    reqB     = 16'h0001;
    reqValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("holdRspY", {16'd0, rspY}, 32'h1234);
      checkOutput("holdState", {30'd0, reqReady, rspValid}, 32'h1);
    end
    reqValid = 1'b0;
    completeHandshake("holdHandshake");
    checkOutput("holdAfterDone", {16'd0, rspY}, 32'h1234);

    // Reset in the middle of a RUN abandons the operation.
    reqOp    = 3'd0;
    reqA     = 16'h1111;
    reqB     = 16'h2222;
    reqCin   = 1'b0;
    reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("runSliceIdx2", {24'd0, aluA, aluB}, 32'h12);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midRstState", {30'd0, reqReady, rspValid}, 32'h2);
    checkOutput("midRstRspY", {16'd0, rspY}, 32'd0);
    checkOutput("midRstFlags", {30'd0, rspCout, rspOvf}, 32'd0);
    checkOutput("midRstAluBus", {20'd0, aluA, aluB, aluOp, aluCin}, 32'd0);

    applyStimulus(3'd0, 16'h0003, 16'h0004, 1'b0, 1'b0, latency);
    checkOutput("addAfterRst", {16'd0, rspY}, 32'h0007);
    checkOutput("addAfterRstLatency", latency, 32'd5);
    completeHandshake("addAfterRstHandshake");

`ifdef ALU_SEQ_ZERO_FLAG_EN
    applyStimulus(3'd4, 16'hF0F0, 16'h0F0F, 1'b0, 1'b0, latency);
    checkOutput("andZeroY", {16'd0, rspY}, 32'h0000);
    checkOutput("andZeroFlag", {31'd0, rspZero}, 32'd1);
    completeHandshake("andZeroHandshake");

    applyStimulus(3'd4, 16'hF0F0, 16'h1F0F, 1'b0, 1'b0, latency);
    checkOutput("andNonZeroY", {16'd0, rspY}, 32'h1000);
    checkOutput("andNonZeroFlag", {31'd0, rspZero}, 32'd0);
    completeHandshake("andNonZeroHandshake");
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
